paging_system: RTL and testbench

Virtual-memory paging subsystem between the CPU bus and backing storage. It has three parts:

- a translation stage (VMEM) that maps CPU virtual addresses to physical addresses;
- a direct-mapped, write-back, write-allocate L1 data cache;
- a word-wide main memory with fixed access latency.

It serves one CPU read or write at a time and executes maintenance operations requested on a separate op port.

---
 rtl/paging_system_pkg.sv | 24 ++
 rtl/paging_system_main_memory.sv | 41 ++++
 rtl/paging_system.sv | 205 ++++++++++++++++++++
 tb/tb_paging_system.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paging_system_pkg.sv
// Shared definitions for the paging subsystem: maintenance op codes, controller
// states and the saturating counter helper.
package paging_system_pkg;

  localparam logic [3:0] OP_INVALIDATE = 4'b0010;
  localparam logic [3:0] OP_FLUSH      = 4'b0011;
  localparam logic [3:0] OP_CLR_STATS  = 4'b0100;
  localparam logic [3:0] OP_PRINT      = 4'b1001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_FILL,
    S_RESPOND,
    S_OP_EXEC,
    S_OP_FLUSH
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/paging_system_main_memory.sv
// Word-wide backing store. A held request completes after MEM_LAT cycles; ack is
// combinational on the final cycle so the caller can move on at that edge.
module paging_system_main_memory #(
  parameter int MEM_WORDS = 16384,
  parameter int MEM_LAT   = 4,
  parameter int AW        = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          ack,
  output logic [31:0]   rdata
);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   mem_q [MEM_WORDS];

  assign ack   = req && (cnt_q == '0);
  assign rdata = mem_q[addr];

  always_comb begin
    cnt_d = cnt_q;
    if (!req || ack) cnt_d = CW'(MEM_LAT - 1);
    else             cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= CW'(MEM_LAT - 1);
    else        cnt_q <= cnt_d;
  end

  // Contents survive reset; only a completed write lands in the array.
  always_ff @(posedge clk) begin
    if (ack && we) mem_q[addr] <= wdata;
  end

endmodule

// File: rtl/paging_system.sv
// Paging subsystem: page-table translation, direct-mapped write-back cache, main memory.
// state | meaning
// IDLE | wait for op or CPU request ; LOOKUP | translate, tag compare
// WRITEBACK | evict dirty victim ; FILL | load line from memory
// RESPOND | CPU_ACK handshake ; OP_EXEC | run latched op ; OP_FLUSH | walk lines writing back dirty data
module paging_system
  import paging_system_pkg::*;
#(
  parameter int LINES        = 64,
  parameter int MEM_WORDS    = 16384,
  parameter int MEM_LAT      = 4,
  parameter int FRAME_OFFSET = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CPU_Request,
  input  logic [31:0] CPU_Address,
  input  logic        CPU_WE,
  inout  wire  [31:0] CPU_dataBus,
  output logic        CPU_ACK,
  input  logic        OP_Request,
  input  logic [3:0]  OPERATIONS,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IW = $clog2(LINES);
  localparam int WW = 14;
  localparam int TW = WW - IW;

  state_e            state_q, state_d;
  logic              ack_q, ack_d, we_q, we_d;
  logic [WW-1:0]     va_q, va_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0]       hit_q, hit_d, miss_q, miss_d;
  logic [LINES-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  logic              op_prev_q, op_pend_q, op_pend_d;
  logic [3:0]        op_code_q, op_code_d, cur_op_q, cur_op_d;
  logic [IW-1:0]     fl_idx_q, fl_idx_d;
  logic [3:0]        pt_q [16];
  logic [TW-1:0]     tag_q [LINES];
  logic [31:0]       data_q [LINES];

  logic [WW-1:0]     pa_word, mem_addr;
  logic [IW-1:0]     idx, line_idx;
  logic [TW-1:0]     tag, line_tag;
  logic [31:0]       line_data, mem_wdata, mem_rdata;
  logic              line_we, mem_req, mem_we, mem_ack, hit, op_edge;
  logic              unused_bits;

  assign unused_bits = ^{CPU_Address[31:16], CPU_Address[1:0]};
  assign pa_word     = {pt_q[va_q[13:10]], va_q[9:0]};
  assign idx         = pa_word[IW-1:0];
  assign tag         = pa_word[WW-1:IW];
  assign hit         = valid_q[idx] && (tag_q[idx] == tag);
  assign op_edge     = OP_Request && !op_prev_q;

  assign CPU_ACK     = ack_q;
  assign hit_count   = hit_q;
  assign miss_count  = miss_q;
  assign CPU_dataBus = (ack_q && !we_q) ? rdata_q : 'z;

  always_comb begin
    state_d   = state_q;   ack_d     = ack_q;     we_d      = we_q;
    va_d      = va_q;      wdata_d   = wdata_q;   rdata_d   = rdata_q;
    hit_d     = hit_q;     miss_d    = miss_q;    valid_d   = valid_q;
    dirty_d   = dirty_q;   op_pend_d = op_pend_q; op_code_d = op_code_q;
    cur_op_d  = cur_op_q;  fl_idx_d  = fl_idx_q;
    mem_req   = 1'b0;      mem_we    = 1'b0;      mem_addr  = pa_word;
    mem_wdata = wdata_q;   line_we   = 1'b0;      line_idx  = idx;
    line_tag  = tag;       line_data = wdata_q;

    // A later edge simply replaces whatever code is still waiting.
    if (op_edge) begin
      op_pend_d = 1'b1;
      op_code_d = OPERATIONS;
    end

    unique case (state_q)
      S_IDLE: begin
        if (op_pend_q) begin
          state_d   = S_OP_EXEC;
          cur_op_d  = op_code_q;
          op_pend_d = op_edge;
        end else if (CPU_Request && !ack_q) begin
          state_d = S_LOOKUP;
          va_d    = CPU_Address[15:2];
          we_d    = CPU_WE;
          wdata_d = CPU_dataBus;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          hit_d   = sat_inc(hit_q);
          state_d = S_RESPOND;
          rdata_d = data_q[idx];
          if (we_q) begin
            line_we      = 1'b1;
            dirty_d[idx] = 1'b1;
          end
        end else begin
          miss_d  = sat_inc(miss_q);
          state_d = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_FILL;
        end
      end
      S_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[idx], idx};
        mem_wdata = data_q[idx];
        if (mem_ack) state_d = S_FILL;
      end
      S_FILL: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          line_we      = 1'b1;
          line_data    = we_q ? wdata_q : mem_rdata;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = we_q;
          rdata_d      = mem_rdata;
          state_d      = S_RESPOND;
        end
      end
      S_RESPOND: begin
        if (!ack_q) begin
          ack_d = 1'b1;
        end else if (!CPU_Request) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_OP_EXEC: begin
        state_d = S_IDLE;
        case (cur_op_q)
          OP_INVALIDATE: begin
            valid_d = '0;
            dirty_d = '0;
          end
          OP_FLUSH: begin
            state_d  = S_OP_FLUSH;
            fl_idx_d = '0;
          end
          OP_CLR_STATS: begin
            hit_d  = '0;
            miss_d = '0;
          end
          default: ;
        endcase
      end
      S_OP_FLUSH: begin
        if (valid_q[fl_idx_q] && dirty_q[fl_idx_q]) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {tag_q[fl_idx_q], fl_idx_q};
          mem_wdata = data_q[fl_idx_q];
        end
        if (!mem_req || mem_ack) begin
          dirty_d[fl_idx_q] = 1'b0;
          if (fl_idx_q == IW'(LINES - 1)) state_d = S_IDLE;
          else fl_idx_d = fl_idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;   ack_q     <= 1'b0;   we_q      <= 1'b0;
      va_q      <= '0;       wdata_q   <= '0;     rdata_q   <= '0;
      hit_q     <= '0;       miss_q    <= '0;     valid_q   <= '0;
      dirty_q   <= '0;       op_prev_q <= 1'b0;   op_pend_q <= 1'b0;
      op_code_q <= '0;       cur_op_q  <= '0;     fl_idx_q  <= '0;
      for (int i = 0; i < 16; i++) pt_q[i] <= 4'((i + FRAME_OFFSET) % 16);
    end else begin
      state_q   <= state_d;  ack_q     <= ack_d;  we_q      <= we_d;
      va_q      <= va_d;     wdata_q   <= wdata_d; rdata_q  <= rdata_d;
      hit_q     <= hit_d;    miss_q    <= miss_d; valid_q   <= valid_d;
      dirty_q   <= dirty_d;  op_prev_q <= OP_Request; op_pend_q <= op_pend_d;
      op_code_q <= op_code_d; cur_op_q <= cur_op_d; fl_idx_q  <= fl_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= line_data;
    end
  end

  paging_system_main_memory #(
    .MEM_WORDS (MEM_WORDS),
    .MEM_LAT   (MEM_LAT),
    .AW        (WW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (mem_req),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .ack   (mem_ack),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_paging_system.sv
// Bench for paging_system: fixed vector table, hand-built op/reset sequences and
// randomized traffic against a behavioural cache/memory model.
module tb_paging_system;
  import paging_system_pkg::*;

  localparam int LINES        = 64;
  localparam int MEM_LAT      = 4;
  localparam int FRAME_OFFSET = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        CPU_Request = 1'b0;
  logic [31:0] CPU_Address = '0;
  logic        CPU_WE = 1'b0;
  wire  [31:0] CPU_dataBus;
  logic        CPU_ACK;
  logic        OP_Request = 1'b0;
  logic [3:0]  OPERATIONS = '0;
  logic [31:0] hit_count, miss_count;
  logic        drv = 1'b0;
  logic [31:0] drv_data = '0;

  assign CPU_dataBus = drv ? drv_data : 'z;
  always #5 clk = ~clk;

  paging_system #(
    .LINES(LINES), .MEM_WORDS(16384), .MEM_LAT(MEM_LAT), .FRAME_OFFSET(FRAME_OFFSET)
  ) dut (
    .clk(clk), .rst_n(rst_n), .CPU_Request(CPU_Request), .CPU_Address(CPU_Address),
    .CPU_WE(CPU_WE), .CPU_dataBus(CPU_dataBus), .CPU_ACK(CPU_ACK),
    .OP_Request(OP_Request), .OPERATIONS(OPERATIONS),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural reference: memory as a sparse word map, cache as per-line records.
  bit [31:0]   m_mem [int];
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  int          m_tag [LINES];
  bit [31:0]   m_data [LINES];
  int unsigned m_hits = 0, m_misses = 0;

  function automatic bit [31:0] mread(input int a);
    return m_mem.exists(a) ? m_mem[a] : 32'd0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits = 0;
    m_misses = 0;
  endfunction

  function automatic void model_access(input logic [31:0] va, input bit we,
                                       input logic [31:0] wd, output logic [31:0] rd,
                                       output int lat);
    int frame, word, idx, tag;
    frame = (int'(va[15:12]) + FRAME_OFFSET) % 16;
    word  = frame * 1024 + int'(va[11:2]);
    idx   = word % LINES;
    tag   = word / LINES;
    if (m_valid[idx] && m_tag[idx] == tag) begin
      m_hits++;
      lat = 2;
    end else begin
      m_misses++;
      lat = 2 + MEM_LAT;
      if (m_valid[idx] && m_dirty[idx]) begin
        m_mem[m_tag[idx] * LINES + idx] = m_data[idx];
        lat += MEM_LAT;
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
      m_data[idx]  = mread(word);
    end
    if (we) begin
      m_data[idx]  = wd;
      m_dirty[idx] = 1'b1;
    end
    rd = m_data[idx];
  endfunction

  function automatic void model_op(input logic [3:0] code);
    case (code)
      OP_INVALIDATE: for (int i = 0; i < LINES; i++) begin
        m_valid[i] = 1'b0;
        m_dirty[i] = 1'b0;
      end
      OP_FLUSH: for (int i = 0; i < LINES; i++) begin
        if (m_valid[i] && m_dirty[i]) begin
          m_mem[m_tag[i] * LINES + i] = m_data[i];
          m_dirty[i] = 1'b0;
        end
      end
      OP_CLR_STATS: begin
        m_hits = 0;
        m_misses = 0;
      end
      default: ;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cpu_access(input logic [31:0] va, input bit we, input logic [31:0] wd,
                            output logic [31:0] rd, output int lat);
    int cyc;
    cyc = 0;
    rd  = 'x;
    lat = -1;
    @(negedge clk);
    CPU_Address = va;
    CPU_WE      = we;
    drv         = we;
    drv_data    = wd;
    CPU_Request = 1'b1;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (CPU_ACK) break;
    end
    if (CPU_ACK) begin
      lat = cyc - 1;
      rd  = CPU_dataBus;
    end
    @(negedge clk);
    CPU_Request = 1'b0;
    drv         = 1'b0;
    cyc = 0;
    while (CPU_ACK && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_access(input string name, input logic [31:0] va, input bit we,
                           input logic [31:0] wd);
    logic [31:0] erd, ard;
    int elat, alat;
    model_access(va, we, wd, erd, elat);
    cpu_access(va, we, wd, ard, alat);
    check({name, " latency"}, 32'(alat), 32'(elat));
    if (!we) check({name, " data"}, ard, erd);
  endtask

  task automatic pulse_op(input logic [3:0] code);
    @(negedge clk);
    OPERATIONS = code;
    OP_Request = 1'b1;
    @(negedge clk);
    OP_Request = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] code);
    pulse_op(code);
    model_op(code);
    repeat (LINES * (MEM_LAT + 1) + 8) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string name);
    check({name, " hits"}, hit_count, 32'(m_hits));
    check({name, " misses"}, miss_count, 32'(m_misses));
  endtask

  typedef struct {
    logic [31:0] va;
    bit          we;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat, cyc;
    logic [31:0] va;
    logic [3:0] codes [4];

    // Offset 1: VA 0x0 -> frame 1, VA 0x1000 -> frame 2; 0x10/0x110 share line 4.
    tbl[0] = '{32'h0000_0010, 1'b0, 32'h0,         32'h0,         2 + MEM_LAT};
    tbl[1] = '{32'h0000_0010, 1'b1, 32'h2,         32'h0,         2};
    tbl[2] = '{32'h0000_0010, 1'b0, 32'h0,         32'h2,         2};
    tbl[3] = '{32'h0000_0110, 1'b0, 32'h0,         32'h0,         2 + 2 * MEM_LAT};
    tbl[4] = '{32'h0000_0010, 1'b0, 32'h0,         32'h2,         2 + MEM_LAT};
    tbl[5] = '{32'hABCD_0010, 1'b0, 32'h0,         32'h2,         2};
    tbl[6] = '{32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 32'h0,         2 + MEM_LAT};
    tbl[7] = '{32'h0000_1000, 1'b0, 32'h0,         32'h0,         2 + 2 * MEM_LAT};
    tbl[8] = '{32'h0000_0000, 1'b0, 32'h0,         32'hDEAD_BEEF, 2 + MEM_LAT};
    codes[0] = OP_FLUSH;
    codes[1] = OP_INVALIDATE;
    codes[2] = OP_CLR_STATS;
    codes[3] = 4'b0101;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset ack", {31'd0, CPU_ACK}, 32'd0);
    check("reset hits", hit_count, 32'd0);
    check("reset misses", miss_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      model_access(tbl[i].va, tbl[i].we, tbl[i].wd, rd, lat);
      cpu_access(tbl[i].va, tbl[i].we, tbl[i].wd, rd, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      if (!tbl[i].we) check($sformatf("vec%0d data", i), rd, tbl[i].exp_rd);
    end
    check("vec hits", hit_count, 32'd3);
    check("vec misses", miss_count, 32'd6);

    do_access("wr 0x20", 32'h20, 1'b1, 32'h55);
    run_op(OP_FLUSH);
    run_op(OP_INVALIDATE);
    do_access("flushed rd 0x20", 32'h20, 1'b0, '0);
    do_access("wr2 0x20", 32'h20, 1'b1, 32'h77);
    run_op(OP_INVALIDATE);
    do_access("discarded rd 0x20", 32'h20, 1'b0, '0);
    run_op(OP_CLR_STATS);
    check("clr hits", hit_count, 32'd0);
    check("clr misses", miss_count, 32'd0);
    do_access("post-clr rd", 32'h20, 1'b0, '0);
    run_op(OP_PRINT);
    $display("hit_count=%0d miss_count=%0d", hit_count, miss_count);
    check_counts("print op");
    run_op(4'b0101);
    do_access("unknown op rd", 32'h20, 1'b0, '0);
    check_counts("unknown op");

    fork
      do_access("pend miss", 32'h0000_3000, 1'b0, '0);
      begin
        repeat (3) @(negedge clk);
        pulse_op(OP_CLR_STATS);
      end
    join
    model_op(OP_CLR_STATS);
    repeat (5) @(posedge clk);
    #1;
    check_counts("pending op");

    fork
      do_access("overwrite miss", 32'h0000_3100, 1'b0, '0);
      begin
        @(negedge clk);
        pulse_op(OP_INVALIDATE);
        pulse_op(OP_CLR_STATS);
      end
    join
    model_op(OP_CLR_STATS);
    repeat (5) @(posedge clk);
    do_access("overwrite rehit", 32'h0000_3100, 1'b0, '0);
    check_counts("overwrite");

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        run_op(codes[$urandom_range(0, 3)]);
      end else begin
        va = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 3)) << 12)
           | (32'($urandom_range(0, 1)) << 8) | (32'($urandom_range(0, 3)) << 2)
           | ($urandom & 32'd3);
        do_access($sformatf("rand%0d", n), va, bit'($urandom_range(0, 1)), $urandom);
      end
    end
    check_counts("random");

    run_op(OP_INVALIDATE);
    @(negedge clk);
    CPU_Address = 32'h40;
    CPU_WE      = 1'b0;
    CPU_Request = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst in fill ack", {31'd0, CPU_ACK}, 32'd0);
    check("rst in fill state", 32'(dut.state_q), 32'(S_IDLE));
    CPU_Request = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    CPU_Address = 32'h44;
    CPU_Request = 1'b1;
    cyc = 0;
    while (!CPU_ACK && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ack before reset", {31'd0, CPU_ACK}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst in respond ack", {31'd0, CPU_ACK}, 32'd0);
    check("rst in respond misses", miss_count, 32'd0);
    CPU_Request = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    do_access("after rst 0x20", 32'h20, 1'b0, '0);
    do_access("after rst 0x0", 32'h0, 1'b0, '0);
    do_access("after rst 0x3100", 32'h3100, 1'b0, '0);
    check_counts("after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
